popcount_shift_accumulator: RTL and testbench

Downstream consumer of the 16-lane popcount adder tree in the bit-serial datapath. Accepts one popcount per input bit-plane, LSB plane first, and shift-adds it into a running sum. After NBITS planes it presents the full dot-product result on a valid/ready output. Supports two's-complement activations: the MSB plane is subtracted.

---
 rtl/popcount_shift_accumulator_if.sv | 25 ++
 rtl/popcount_shift_accumulator.sv | 108 ++++++++++
 tb/tb_popcount_shift_accumulator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/popcount_shift_accumulator_if.sv
// Handshake bundle between the popcount adder tree, the shift accumulator
// and the result consumer. Plane stream in, frame result out.
interface popcount_shift_accumulator_if #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 13
);
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  // Producer/consumer side: drives planes and result acceptance
  modport master (
    output in_valid, in_cnt, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_cnt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/popcount_shift_accumulator.sv
// Bit-serial shift accumulator: takes one popcount per activation bit-plane,
// LSB plane first, and weights it by 2^plane. For signed activations the MSB
// plane carries weight -2^(NBITS-1), so its term is subtracted. The finished
// frame result is held on a valid/ready output until taken.
module popcount_shift_accumulator #(
  parameter int LANES  = 16,
  parameter int CNT_W  = 5,
  parameter int NBITS  = 8,
  parameter int SIGNED = 1,
  parameter int ACC_W  = 13,
  localparam int IDX_W = $clog2(NBITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  popcount_shift_accumulator_if.slave   bus,
  output logic [IDX_W-1:0]              plane_idx,
  output logic                          cnt_err
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(LANES);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             cnt_err_q, cnt_err_d;

  logic             accept;
  logic             last_plane;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;

  // in_ready depends only on state, never on out_ready
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign plane_idx     = idx_q;
  assign cnt_err       = cnt_err_q;

  assign accept     = bus.in_valid && (state_q == ACCUM);
  assign last_plane = (idx_q == LAST_IDX);

  // Weighted plane term and the running sum it produces; plane 0 restarts the sum
  always_comb begin
    term = {{(ACC_W-CNT_W){1'b0}}, bus.in_cnt} << idx_q;
    base = (idx_q == '0) ? '0 : acc_q;
    if ((SIGNED != 0) && last_plane) sum = base - term;
    else                             sum = base + term;
  end

  // Next-state: clear beats any handshake, then plane accept, then result drain
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_err_d   = cnt_err_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (bus.in_cnt > MAX_CNT) cnt_err_d = 1'b1;
      if (last_plane) begin
        out_data_d  = sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
        state_d     = HOLD;
      end else begin
        acc_d = sum;
        idx_d = idx_q + IDX_W'(1);
      end
    end else if ((state_q == HOLD) && out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  // State registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_popcount_shift_accumulator.sv
// Directed bench: an unsigned and a signed accumulator see identical plane
// streams; frame vectors come from a table, corner cases are hand sequenced.
module tb_popcount_shift_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [4:0] in_cnt = '0;
  logic out_ready = 1'b0;
  logic [2:0] pidx_u, pidx_s;
  logic err_u, err_s;

  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  popcount_shift_accumulator_if #(.CNT_W(5), .ACC_W(13)) ifu ();
  popcount_shift_accumulator_if #(.CNT_W(5), .ACC_W(13)) ifs ();

  assign ifu.in_valid  = in_valid;
  assign ifu.in_cnt    = in_cnt;
  assign ifu.out_ready = out_ready;
  assign ifs.in_valid  = in_valid;
  assign ifs.in_cnt    = in_cnt;
  assign ifs.out_ready = out_ready;

  popcount_shift_accumulator #(.LANES(16), .CNT_W(5), .NBITS(8), .SIGNED(0), .ACC_W(13)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifu.slave),
    .plane_idx(pidx_u), .cnt_err(err_u)
  );

  popcount_shift_accumulator #(.LANES(16), .CNT_W(5), .NBITS(8), .SIGNED(1), .ACC_W(13)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifs.slave),
    .plane_idx(pidx_s), .cnt_err(err_s)
  );

  typedef struct {
    logic [7:0][4:0] cnt;    // cnt[p] = popcount of plane p
    logic [12:0]     exp_u;
    logic [12:0]     exp_s;
    bit              bubble; // idle cycle before every plane
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both_idx(input string name, input logic [2:0] exp);
    check({name, " idx_u"}, 32'(pidx_u), 32'(exp));
    check({name, " idx_s"}, 32'(pidx_s), 32'(exp));
  endtask

  // Push 8 planes; leaves both DUTs holding the result with out_ready low
  task automatic feed_frame(input logic [7:0][4:0] c, input logic [12:0] eu,
                            input logic [12:0] es, input bit bubble, input string tag);
    for (int p = 0; p < 8; p++) begin
      if (bubble) begin
        in_valid = 1'b0;
        in_cnt   = 5'd31;
        step();
        check_both_idx({tag, " bubble"}, 3'(p));
      end
      in_valid = 1'b1;
      in_cnt   = c[p];
      step();
      if (p < 7) begin
        check({tag, " mid out_valid"}, 32'(ifu.out_valid), 32'd0);
        check_both_idx({tag, " plane"}, 3'(p + 1));
      end
    end
    in_valid = 1'b0;
    in_cnt   = '0;
    check({tag, " out_valid_u"}, 32'(ifu.out_valid), 32'd1);
    check({tag, " out_valid_s"}, 32'(ifs.out_valid), 32'd1);
    check({tag, " data_u"}, 32'(ifu.out_data), 32'(eu));
    check({tag, " data_s"}, 32'(ifs.out_data), 32'(es));
    check({tag, " in_ready_hold"}, 32'(ifu.in_ready), 32'd0);
    check_both_idx({tag, " wrap"}, 3'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " drained_u"}, 32'(ifu.out_valid), 32'd0);
    check({tag, " drained_s"}, 32'(ifs.out_valid), 32'd0);
    check({tag, " in_ready_back"}, 32'(ifs.in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{cnt: {8{5'd16}}, exp_u: 13'h0FF0, exp_s: 13'h1FF0, bubble: 1'b0};
    vecs[1] = '{cnt: {35'd0, 5'd3}, exp_u: 13'd3, exp_s: 13'd3, bubble: 1'b0};
    vecs[2] = '{cnt: {5'd1, 35'd0}, exp_u: 13'd128, exp_s: 13'h1F80, bubble: 1'b0};
    vecs[3] = '{cnt: {8{5'd1}}, exp_u: 13'd255, exp_s: 13'h1FFF, bubble: 1'b0};
    vecs[4] = '{cnt: {5'd9, 5'd0, 5'd1, 5'd16, 5'd2, 5'd7, 5'd0, 5'd5},
                exp_u: 13'd1489, exp_s: 13'h1CD1, bubble: 1'b0};
    vecs[5] = '{cnt: '0, exp_u: 13'd0, exp_s: 13'd0, bubble: 1'b0};
    vecs[6] = '{cnt: {8{5'd16}}, exp_u: 13'h0FF0, exp_s: 13'h1FF0, bubble: 1'b1};

    // Reset values
    #1 rst_n = 1'b0;
    #12;
    check("rst out_valid", 32'(ifu.out_valid), 32'd0);
    check("rst out_data", 32'(ifs.out_data), 32'd0);
    check("rst in_ready", 32'(ifu.in_ready), 32'd1);
    check_both_idx("rst", 3'd0);
    check("rst cnt_err", 32'(err_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      feed_frame(vecs[i].cnt, vecs[i].exp_u, vecs[i].exp_s, vecs[i].bubble, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: result held, planes ignored while out_ready low
    feed_frame({8{5'd16}}, 13'h0FF0, 13'h1FF0, 1'b0, "bp");
    in_valid = 1'b1;
    in_cnt   = 5'd9;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp hold data_u", 32'(ifu.out_data), 32'h0FF0);
      check("bp hold data_s", 32'(ifs.out_data), 32'h1FF0);
      check("bp hold valid", 32'(ifu.out_valid), 32'd1);
      check("bp in_ready", 32'(ifu.in_ready), 32'd0);
      check_both_idx("bp no consume", 3'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp handshake", 32'(ifu.out_valid), 32'd0);
    check_both_idx("bp handshake", 3'd0);
    step();
    check_both_idx("bp next plane0", 3'd1);

    // Clear with a simultaneous plane: plane dropped, frame restarts
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_cnt = 5'd16;
    for (int k = 0; k < 3; k++) step();
    check_both_idx("abort pre", 3'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    check_both_idx("abort", 3'd0);
    feed_frame({8{5'd1}}, 13'd255, 13'h1FFF, 1'b0, "post_abort");

    // Clear while holding a result drops it
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear hold valid", 32'(ifs.out_valid), 32'd0);
    check("clear hold ready", 32'(ifs.in_ready), 32'd1);

    // Async reset mid-frame, no clock edge
    in_valid = 1'b1;
    in_cnt   = 5'd4;
    step();
    step();
    in_valid = 1'b0;
    check_both_idx("pre async", 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check_both_idx("async mid", 3'd0);
    #3 rst_n = 1'b1;

    // Async reset while holding a result
    feed_frame({8{5'd16}}, 13'h0FF0, 13'h1FF0, 1'b0, "pre_rst_hold");
    #2 rst_n = 1'b0;
    #1;
    check("async hold valid", 32'(ifu.out_valid), 32'd0);
    check("async hold data", 32'(ifu.out_data), 32'd0);
    check("async hold ready", 32'(ifu.in_ready), 32'd1);
    #3 rst_n = 1'b1;

    // Out-of-range count: flagged, still accumulated, survives clear
    check("err before", 32'(err_u), 32'd0);
    feed_frame({35'd0, 5'd17}, 13'd17, 13'd17, 1'b0, "cnt17");
    check("err set_u", 32'(err_u), 32'd1);
    check("err set_s", 32'(err_s), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("err after clear", 32'(err_s), 32'd1);
    check("clear drops 17", 32'(ifs.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
